// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests into a prefix stall bus, sequences
// flushes with optional refill hold and watchdog. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned         STAGES        = 6,
    parameter int unsigned         NREQ          = 2,
    parameter logic [8*NREQ-1:0]   REQ_STAGE_MAP = {8'd3, 8'd2},
    parameter int unsigned         REFILL_CYCLES = 0,
    parameter int unsigned         TIMEOUT       = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stallreq,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              stall_timeout,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_count
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RF_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_REFILL
    } state_t;

    state_t            state, state_nxt;
    logic [RF_W-1:0]   rf_cnt, rf_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [STAGES-1:0] req_stall;
    logic [7:0]        field;
    logic              wd_inc;

    // Source i stalls every stage up to and including its mapped stage.
    always_comb begin
        req_stall = '0;
        field     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            field = REQ_STAGE_MAP[8*i +: 8];
            if (stallreq[i]) begin
                for (int unsigned k = 0; k < STAGES; k++) begin
                    if (k <= 32'(field)) req_stall[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall = '0;
        if (rst) begin
            case (state)
                S_RUN:    stall = req_stall;
                S_REFILL: begin
                    stall    = req_stall;
                    stall[0] = 1'b1;
                end
                default:  stall = '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        rf_nxt    = rf_cnt;
        case (state)
            S_RUN: begin
                if (flush_req) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_req) begin
                    state_nxt = S_FLUSH;
                end else if (REFILL_CYCLES > 0) begin
                    state_nxt = S_REFILL;
                    rf_nxt    = RF_W'(REFILL_CYCLES - 1);
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_REFILL: begin
                if (flush_req) begin
                    state_nxt = S_FLUSH;
                end else if (rf_cnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    rf_nxt = rf_cnt - 1'b1;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_RUN;
            rf_cnt <= '0;
            new_pc <= '0;
        end else begin
            state  <= state_nxt;
            rf_cnt <= rf_nxt;
            if (flush_req) new_pc <= flush_pc;
        end
    end

    assign flush  = (state == S_FLUSH);
    assign wd_inc = (req_stall != '0) && (state != S_FLUSH);

    // Flag is set on the same edge the counter lands on TIMEOUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!wd_inc) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_inc && (wd_cnt == WD_W'(TIMEOUT - 1))) stall_timeout <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] psc_q, pfc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            psc_q <= '0;
            pfc_q <= '0;
        end else begin
            if ((stall != '0) && (psc_q != '1)) psc_q <= psc_q + 1'b1;
            if (flush && (pfc_q != '1))         pfc_q <= pfc_q + 1'b1;
        end
    end

    assign perf_stall_cycles = psc_q;
    assign perf_flush_count  = pfc_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_count  = '0;
`endif

endmodule
